// File: rtl/int_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// int_div_unit_pkg
// Shared types and helpers for the integer divide/remainder execute unit:
//   - op / result structs exchanged with the register-file stage
//   - opcode constants for the eight M-extension divide ops
//   - div_kind_e + decode helpers (is_div_op, decode_div)
//   - FSM state encoding of the unit
// -----------------------------------------------------------------------------
package int_div_unit_pkg;

    localparam int DATA_W = 64;   // width of operand/result fields in the structs
    localparam int PREG_W = 6;    // physical register index width
    localparam int AL_W   = 6;    // active-list index width
    localparam int OPC_W  = 5;    // internal uop opcode width

    typedef logic [OPC_W-1:0] opcode_t;

    // The divide ops occupy one contiguous block of the uop opcode space.
    localparam opcode_t OP_DIV   = 5'h10;
    localparam opcode_t OP_DIVU  = 5'h11;
    localparam opcode_t OP_REM   = 5'h12;
    localparam opcode_t OP_REMU  = 5'h13;
    localparam opcode_t OP_DIVW  = 5'h14;
    localparam opcode_t OP_DIVUW = 5'h15;
    localparam opcode_t OP_REMW  = 5'h16;
    localparam opcode_t OP_REMUW = 5'h17;

    typedef enum logic [1:0] {
        DIV,
        DIVU,
        REM,
        REMU
    } div_kind_e;

    typedef struct packed {
        div_kind_e kind;
        logic      is_w;
    } div_dec_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } div_state_e;

    typedef struct packed {
        logic              valid;
        opcode_t           opcode;
        logic [PREG_W-1:0] rd;
        logic              rd_exist;
        logic [DATA_W-1:0] rs1_val;
        logic [DATA_W-1:0] rs2_val;
        logic [AL_W-1:0]   al_idx;
    } vuop_back_t;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] rd;
        logic [DATA_W-1:0] rd_val;
        logic [AL_W-1:0]   al_idx;
    } vuop_result_t;

    function automatic logic is_div_op(opcode_t op);
        return (op >= OP_DIV) && (op <= OP_REMUW);
    endfunction

    function automatic div_dec_t decode_div(opcode_t op);
        div_dec_t d;
        d.kind = DIV;
        d.is_w = 1'b0;
        case (op)
            OP_DIV:   d.kind = DIV;
            OP_DIVU:  d.kind = DIVU;
            OP_REM:   d.kind = REM;
            OP_REMU:  d.kind = REMU;
            OP_DIVW:  begin d.kind = DIV;  d.is_w = 1'b1; end
            OP_DIVUW: begin d.kind = DIVU; d.is_w = 1'b1; end
            OP_REMW:  begin d.kind = REM;  d.is_w = 1'b1; end
            OP_REMUW: begin d.kind = REMU; d.is_w = 1'b1; end
            default:  ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/int_div_unit_if.sv
// -----------------------------------------------------------------------------
// int_div_unit_if
// Bundles the divide unit's op/result traffic.
//   op_in     : op from the register-file stage
//   op_out    : result feedback to the register file / active list
//   stall_out : high while the unit cannot take a new op
//   flush_in  : kill all in-flight work
// modport master = register-file side, modport slave = divide unit side.
// -----------------------------------------------------------------------------
interface int_div_unit_if;

    int_div_unit_pkg::vuop_back_t   op_in;
    int_div_unit_pkg::vuop_result_t op_out;
    logic                           stall_out;
    logic                           flush_in;

    modport master (
        output op_in,
        output flush_in,
        input  op_out,
        input  stall_out
    );

    modport slave (
        input  op_in,
        input  flush_in,
        output op_out,
        output stall_out
    );

endinterface

// File: rtl/int_div_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Unsigned radix-2 restoring divider, one quotient bit per clock.
//   clock, reset : clock and synchronous active-high reset
//   start        : load operands and bit count (takes priority over abort)
//   abort        : stop iterating
//   dividend     : unsigned dividend magnitude
//   divisor      : unsigned divisor magnitude (never zero when started)
//   bits         : number of quotient bits to produce (32 or XLEN)
//   quotient     : quotient, final the cycle after done
//   remainder    : remainder, final the cycle after done
//   done         : high during the final iteration
// -----------------------------------------------------------------------------
module div_core #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [CNT_W-1:0] bits,
    output logic [XLEN-1:0]  quotient,
    output logic [XLEN-1:0]  remainder,
    output logic             done
);

    logic [XLEN-1:0]  rem_reg, rem_next;
    logic [XLEN-1:0]  quo_reg, quo_next;
    logic [XLEN-1:0]  dvs_reg, dvs_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] shamt;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    always_comb begin
        // (XLEN+1)-bit partial remainder: the remainder shifted left with the
        // next dividend bit brought in from the top of the quotient register.
        shifted  = {rem_reg, quo_reg[XLEN-1]};
        // Since rem < divisor, shifted < 2*divisor, so bit XLEN of the
        // difference is exactly the borrow of the trial subtraction.
        diff     = shifted - {1'b0, dvs_reg};
        shamt    = CNT_W'(XLEN) - bits;
        rem_next = rem_reg;
        quo_next = quo_reg;
        dvs_next = dvs_reg;
        cnt_next = cnt_reg;
        if (start) begin
            rem_next = '0;
            // Short divides start with the dividend left-aligned so that the
            // MSB-first shift consumes only the meaningful bits.
            quo_next = dividend << shamt;
            dvs_next = divisor;
            cnt_next = bits;
        end else if (abort) begin
            cnt_next = '0;
        end else if (cnt_reg != '0) begin
            if (diff[XLEN]) begin
                rem_next = shifted[XLEN-1:0];
                quo_next = {quo_reg[XLEN-2:0], 1'b0};
            end else begin
                rem_next = diff[XLEN-1:0];
                quo_next = {quo_reg[XLEN-2:0], 1'b1};
            end
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_reg <= '0;
            quo_reg <= '0;
            dvs_reg <= '0;
            cnt_reg <= '0;
        end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            dvs_reg <= dvs_next;
            cnt_reg <= cnt_next;
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;
    assign done      = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/int_div_unit.sv
// -----------------------------------------------------------------------------
// int_div_unit
// Iterative RV64M divide/remainder execute unit (DIV/DIVU/REM/REMU and the W
// variants). Decodes the op, prepares magnitudes, resolves divide-by-zero and
// signed overflow without iterating, runs div_core otherwise, then applies the
// sign fix and packs the result.
//   clock, reset : clock and synchronous active-high reset
//   bus.op_in    : op with operand values already read
//   bus.op_out   : result feedback, valid for exactly one cycle (DONE)
//   bus.stall_out: high while iterating; upstream holds its op
//   bus.flush_in : drop all in-flight work
// -----------------------------------------------------------------------------
module int_div_unit
    import int_div_unit_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter bit SUPPORT_W_OPS = 1'b1
) (
    input logic           clock,
    input logic           reset,
    int_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam bit W_EN  = SUPPORT_W_OPS && (XLEN == 64);

    div_state_e       state_reg, state_next;

    // Accept-side decode and operand preparation
    div_dec_t         dec;
    logic             op_is_div;
    logic             accept;
    logic             is_w, is_signed, is_rem;
    logic [XLEN-1:0]  a_raw, b_raw, a_ext, b_ext, a_mag, b_mag, min_val;
    logic             a_neg, b_neg;
    logic             div_by_zero, overflow, special;
    logic [XLEN-1:0]  special_val;
    logic [CNT_W-1:0] bit_count;

    // Per-op state latched at accept
    logic [PREG_W-1:0] rd_reg;
    logic [AL_W-1:0]   al_idx_reg;
    logic              is_rem_reg, is_w_reg;
    logic              q_neg_reg, r_neg_reg;
    logic              special_reg;
    logic [XLEN-1:0]   special_val_reg;

    // Core interface and result path
    logic              core_done;
    logic [XLEN-1:0]   core_quo, core_rem;
    logic [XLEN-1:0]   q_fix, r_fix, raw_res, final_val;
    vuop_result_t      op_out_c;
    logic              stall_c;

    always_comb begin
        dec       = decode_div(bus.op_in.opcode);
        is_w      = dec.is_w & W_EN;
        is_signed = (dec.kind == DIV) || (dec.kind == REM);
        is_rem    = (dec.kind == REM) || (dec.kind == REMU);
        // W opcodes fall outside the divide set when W support is off.
        op_is_div = is_div_op(bus.op_in.opcode) && (W_EN || !dec.is_w);
        accept    = bus.op_in.valid && op_is_div && (state_reg != S_BUSY) && !bus.flush_in;

        a_raw = bus.op_in.rs1_val[XLEN-1:0];
        b_raw = bus.op_in.rs2_val[XLEN-1:0];
        if (is_w) begin
            a_ext = {{(XLEN-32){is_signed & a_raw[31]}}, a_raw[31:0]};
            b_ext = {{(XLEN-32){is_signed & b_raw[31]}}, b_raw[31:0]};
        end else begin
            a_ext = a_raw;
            b_ext = b_raw;
        end

        a_neg = is_signed && a_ext[XLEN-1];
        b_neg = is_signed && b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        // Most negative value of the operand width, in extended form.
        min_val = is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

        div_by_zero = (b_ext == '0);
        overflow    = is_signed && (a_ext == min_val) && (b_ext == '1);
        special     = div_by_zero || overflow;

        if (div_by_zero) begin
            special_val = is_rem ? a_ext : '1;
        end else begin
            special_val = is_rem ? '0 : min_val;
        end

        bit_count = is_w ? CNT_W'(32) : CNT_W'(XLEN);
    end

    div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .start     (accept && !special),
        .abort     (bus.flush_in),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .bits      (bit_count),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done      (core_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_reg          <= '0;
            al_idx_reg      <= '0;
            is_rem_reg      <= 1'b0;
            is_w_reg        <= 1'b0;
            q_neg_reg       <= 1'b0;
            r_neg_reg       <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= '0;
        end else if (accept) begin
            rd_reg          <= bus.op_in.rd_exist ? bus.op_in.rd : '0;
            al_idx_reg      <= bus.op_in.al_idx;
            is_rem_reg      <= is_rem;
            is_w_reg        <= is_w;
            q_neg_reg       <= a_neg ^ b_neg;
            r_neg_reg       <= a_neg;
            special_reg     <= special;
            special_val_reg <= special_val;
        end
    end

    // Sign fix and W sign-extension of the finished result.
    always_comb begin
        q_fix     = q_neg_reg ? -core_quo : core_quo;
        r_fix     = r_neg_reg ? -core_rem : core_rem;
        raw_res   = special_reg ? special_val_reg : (is_rem_reg ? r_fix : q_fix);
        final_val = is_w_reg ? {{(XLEN-32){raw_res[31]}}, raw_res[31:0]} : raw_res;
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. DONE behaves like IDLE for acceptance, which is what
    // lets a held op start in the same cycle the previous result leaves.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_next = special ? S_DONE : S_BUSY;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (core_done) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (bus.flush_in) begin
            state_next = S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        op_out_c = '0;
        stall_c  = (state_reg == S_BUSY);
        if (state_reg == S_DONE) begin
            op_out_c.valid  = 1'b1;
            op_out_c.rd     = rd_reg;
            op_out_c.rd_val = DATA_W'(final_val);
            op_out_c.al_idx = al_idx_reg;
        end
    end

    assign bus.op_out    = op_out_c;
    assign bus.stall_out = stall_c;

endmodule

// File: tb/tb_int_div_unit.sv
// -----------------------------------------------------------------------------
// tb_int_div_unit
// Directed and randomized checks of int_div_unit against a plain-arithmetic
// reference of the RV64M divide rules. Inputs are driven and outputs sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_int_div_unit;
    import int_div_unit_pkg::*;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_ops = 0;

    always #5 clock = ~clock;

    int_div_unit_if bus ();

    int_div_unit #(
        .XLEN          (64),
        .SUPPORT_W_OPS (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_w_op(opcode_t opc);
        return (opc == OP_DIVW) || (opc == OP_DIVUW) || (opc == OP_REMW) || (opc == OP_REMUW);
    endfunction

    function automatic logic [63:0] ref_result(opcode_t opc, logic [63:0] a, logic [63:0] b);
        longint      sa, sb;
        int          sa32, sb32;
        int unsigned ua32, ub32;
        logic [31:0] r32;
        logic [63:0] r64;
        sa = a; sb = b;
        sa32 = a[31:0]; sb32 = b[31:0];
        ua32 = a[31:0]; ub32 = b[31:0];
        r32 = '0; r64 = '0;
        case (opc)
            OP_DIV: begin
                if (b == 64'd0) r64 = '1;
                else if (a == MIN64 && b == '1) r64 = MIN64;
                else r64 = sa / sb;
            end
            OP_DIVU: begin
                if (b == 64'd0) r64 = '1;
                else r64 = a / b;
            end
            OP_REM: begin
                if (b == 64'd0) r64 = a;
                else if (a == MIN64 && b == '1) r64 = '0;
                else r64 = sa % sb;
            end
            OP_REMU: begin
                if (b == 64'd0) r64 = a;
                else r64 = a % b;
            end
            OP_DIVW: begin
                if (sb32 == 0) r32 = '1;
                else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = 32'h8000_0000;
                else r32 = sa32 / sb32;
            end
            OP_DIVUW: begin
                if (ub32 == 0) r32 = '1;
                else r32 = ua32 / ub32;
            end
            OP_REMW: begin
                if (sb32 == 0) r32 = a[31:0];
                else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = '0;
                else r32 = sa32 % sb32;
            end
            OP_REMUW: begin
                if (ub32 == 0) r32 = a[31:0];
                else r32 = ua32 % ub32;
            end
            default: r64 = '0;
        endcase
        if (is_w_op(opc)) r64 = {{32{r32[31]}}, r32};
        return r64;
    endfunction

    function automatic int ref_latency(opcode_t opc, logic [63:0] a, logic [63:0] b);
        logic w, sgn, zero, ovf;
        w    = is_w_op(opc);
        sgn  = (opc == OP_DIV) || (opc == OP_REM) || (opc == OP_DIVW) || (opc == OP_REMW);
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == MIN64 && b == '1));
        if (zero || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    function automatic vuop_back_t make_op(opcode_t opc, logic [63:0] a, logic [63:0] b,
                                           logic [5:0] rd, logic rd_ex, logic [5:0] al);
        vuop_back_t op;
        op          = '0;
        op.valid    = 1'b1;
        op.opcode   = opc;
        op.rd       = rd;
        op.rd_exist = rd_ex;
        op.rs1_val  = a;
        op.rs2_val  = b;
        op.al_idx   = al;
        return op;
    endfunction

    function automatic logic [63:0] pick_val();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = '0;
            1:       v = '1;
            2:       v = MIN64;
            3:       v = 64'($urandom_range(1, 20));
            4:       v = {$urandom, $urandom};
            5:       v = 64'hFFFF_FFFF_8000_0000;
            default: v = ~64'($urandom_range(0, 20));
        endcase
        return v;
    endfunction

    // Presents one op at the current falling edge, waits for its result and
    // checks latency, stall profile, result fields and the single-cycle pulse.
    task automatic run_op(input opcode_t opc, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] rd, input logic rd_ex, input logic [5:0] al);
        logic [63:0] exp_val;
        int          exp_lat;
        int          lat;
        int          stall_cnt;
        string       t;
        exp_val = ref_result(opc, a, b);
        exp_lat = ref_latency(opc, a, b);
        n_ops++;
        t = $sformatf("op%0d", n_ops);
        bus.op_in = make_op(opc, a, b, rd, rd_ex, al);
        @(posedge clock);
        lat = 0;
        stall_cnt = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clock);
            if (k == 1) bus.op_in.valid = 1'b0;
            if (bus.op_out.valid) lat = k;
            else if (bus.stall_out) stall_cnt++;
        end
        $display("[%s] opc=%h a=%h b=%h -> rd_val=%h rd=%0d al=%0d lat=%0d", t, opc, a, b,
                 bus.op_out.rd_val, bus.op_out.rd, bus.op_out.al_idx, lat);
        check({t, " latency"}, 64'(lat), 64'(exp_lat));
        check({t, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat - 1));
        check({t, " rd_val"}, bus.op_out.rd_val, exp_val);
        check({t, " rd"}, 64'(bus.op_out.rd), 64'(rd_ex ? rd : 6'd0));
        check({t, " al_idx"}, 64'(bus.op_out.al_idx), 64'(al));
        check({t, " stall_in_done"}, 64'(bus.stall_out), 64'd0);
        @(negedge clock);
        check({t, " one_pulse"}, 64'(bus.op_out.valid), 64'd0);
    endtask

    initial begin : main
        int          seen;
        int          pulses, k1, k2;
        logic [63:0] v1, v2;
        vuop_back_t  op2;

        // ---------------- reset state ----------------
        reset       = 1'b1;
        bus.op_in   = '0;
        bus.flush_in = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset valid", 64'(bus.op_out.valid), 64'd0);
        check("reset rd_val", bus.op_out.rd_val, 64'd0);
        check("reset rd", 64'(bus.op_out.rd), 64'd0);
        check("reset al_idx", 64'(bus.op_out.al_idx), 64'd0);
        check("reset stall", 64'(bus.stall_out), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---------------- directed ops ----------------
        run_op(OP_DIV,   64'd100, 64'd7, 6'd5, 1'b1, 6'd3);
        run_op(OP_REM,   -64'sd7, 64'd2, 6'd6, 1'b1, 6'd4);
        run_op(OP_REMU,  64'd7,   64'd2, 6'd7, 1'b1, 6'd5);
        run_op(OP_DIVU,  64'h1234, 64'd0, 6'd8, 1'b1, 6'd6);
        run_op(OP_REM,   64'h1234, 64'd0, 6'd9, 1'b1, 6'd7);
        run_op(OP_DIV,   MIN64, '1, 6'd10, 1'b1, 6'd8);
        run_op(OP_DIVW,  64'hFFFF_FFFF_8000_0000, 64'd2, 6'd11, 1'b1, 6'd9);
        run_op(OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'h10, 6'd12, 1'b1, 6'd10);
        run_op(OP_DIVW,  64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'd13, 1'b1, 6'd11);
        run_op(OP_REMW,  64'hAAAA_AAAA_0000_0010, 64'h5555_5555_0000_0000, 6'd14, 1'b1, 6'd12);
        run_op(OP_DIV,   64'd50, 64'd5, 6'd31, 1'b0, 6'd13);

        // ---------------- non-divide op is ignored ----------------
        bus.op_in = make_op(opcode_t'(5'h00), 64'd10, 64'd2, 6'd1, 1'b1, 6'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.op_out.valid || bus.stall_out) seen++;
        end
        bus.op_in.valid = 1'b0;
        check("non_div ignored", 64'(seen), 64'd0);

        // ---------------- flush mid-BUSY ----------------
        bus.op_in = make_op(OP_DIV, 64'd1000, 64'd3, 6'd2, 1'b1, 6'd2);
        @(posedge clock);               // accepted in cycle T
        @(negedge clock);               // T+1
        bus.op_in.valid = 1'b0;
        seen = 0;
        repeat (9) begin
            @(negedge clock);           // ends at T+10
            if (bus.op_out.valid) seen++;
        end
        bus.flush_in = 1'b1;
        @(negedge clock);               // T+11
        bus.flush_in = 1'b0;
        check("flush stall low", 64'(bus.stall_out), 64'd0);
        check("flush no result", 64'(seen + int'(bus.op_out.valid)), 64'd0);
        run_op(OP_DIV, 64'd9, 64'd3, 6'd4, 1'b1, 6'd5);

        // ---------------- back-to-back ----------------
        op2 = make_op(OP_REMU, 64'd1000, 64'd7, 6'd21, 1'b1, 6'd22);
        bus.op_in = make_op(OP_DIV, 64'd1000, 64'd10, 6'd20, 1'b1, 6'd21);
        @(posedge clock);               // first op accepted in cycle T
        pulses = 0; k1 = 0; k2 = 0; v1 = '0; v2 = '0;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clock);
            if (k == 1) bus.op_in = op2;            // held while stalled
            if (k1 != 0 && k == k1 + 1) bus.op_in.valid = 1'b0;
            if (bus.op_out.valid) begin
                pulses++;
                if (pulses == 1) begin k1 = k; v1 = bus.op_out.rd_val; end
                else if (pulses == 2) begin k2 = k; v2 = bus.op_out.rd_val; end
            end
        end
        $display("[b2b] pulses=%0d at %0d (%h) and %0d (%h)", pulses, k1, v1, k2, v2);
        check("b2b pulses", 64'(pulses), 64'd2);
        check("b2b first at", 64'(k1), 64'd65);
        check("b2b second at", 64'(k2), 64'd130);
        check("b2b first val", v1, 64'd100);
        check("b2b second val", v2, 64'd6);

        // ---------------- reset mid-BUSY ----------------
        bus.op_in = make_op(OP_DIVU, 64'd12345, 64'd17, 6'd3, 1'b1, 6'd3);
        @(posedge clock);
        @(negedge clock);
        bus.op_in.valid = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid reset valid", 64'(bus.op_out.valid), 64'd0);
        check("mid reset stall", 64'(bus.stall_out), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---------------- randomized ----------------
        for (int i = 0; i < 40; i++) begin
            run_op(opcode_t'(OP_DIV + 5'($urandom_range(0, 7))), pick_val(), pick_val(),
                   6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                   6'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
